// File: rtl/sdrc_bank_queue.sv
// sdrc_bank_queue: in-order chunk FIFO with a per-bank open-row table that classifies
// the head entry as PRE/ACT/RW. Optional ACT/pop counters with `define SDR_BANKQ_STATS_EN.

module sdrc_bank_queue_bank (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        set,
  input  logic [11:0] row_in,
  output logic        open,
  output logic [11:0] row
);
  logic        open_d, open_q;
  logic [11:0] row_d, row_q;

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (clr) begin
      open_d = 1'b0;
    end else if (set) begin
      open_d = 1'b1;
      row_d  = row_in;
    end
  end

  // Row is only meaningful while open, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!reset_n) open_q <= 1'b0;
    else          open_q <= open_d;
    row_q <= row_d;
  end

  assign open = open_q;
  assign row  = row_q;
endmodule

module sdrc_bank_queue #(
  parameter int REQ_ID_W = 4,
  parameter int REQ_BW   = 12,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                r2b_req,
  input  logic [REQ_ID_W-1:0] r2b_req_id,
  input  logic [1:0]          r2b_ba,
  input  logic [11:0]         r2b_raddr,
  input  logic [11:0]         r2b_caddr,
  input  logic [REQ_BW-1:0]   r2b_len,
  input  logic                r2b_write,
  input  logic                r2b_start,
  input  logic                r2b_last,
  input  logic                r2b_wrap,
  output logic                b2r_ack,
  output logic                b2r_arb_ok,
  output logic                q_valid,
  output logic [REQ_ID_W-1:0] q_id,
  output logic [1:0]          q_ba,
  output logic [11:0]         q_raddr,
  output logic [11:0]         q_caddr,
  output logic [REQ_BW-1:0]   q_len,
  output logic                q_write,
  output logic                q_start,
  output logic                q_last,
  output logic                q_wrap,
  output logic [1:0]          q_cmd,
  input  logic                x2q_pre_all,
  input  logic                x2q_pre,
  input  logic                x2q_act,
  input  logic                x2q_pop,
  output logic [15:0]         act_cnt,
  output logic [15:0]         pop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] CMD_RW  = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_PRE = 2'b10;

  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic [1:0]          ba;
    logic [11:0]         raddr;
    logic [11:0]         caddr;
    logic [REQ_BW-1:0]   len;
    logic                write;
    logic                start;
    logic                last;
    logic                wrap;
  } req_t;

  req_t [DEPTH-1:0] mem_d, mem_q;
  logic [CNT_W-1:0] wptr_d, wptr_q, rptr_d, rptr_q, cnt_d, cnt_q;
  req_t             in_req, head;
  logic             head_vld, push, pop, pre_eff, act_eff;
  logic [3:0]       bank_open;
  logic [3:0][11:0] bank_row;
  logic [1:0]       cmd;

  assign in_req = '{id: r2b_req_id, ba: r2b_ba, raddr: r2b_raddr, caddr: r2b_caddr,
                    len: r2b_len, write: r2b_write, start: r2b_start, last: r2b_last,
                    wrap: r2b_wrap};
  assign head_vld = (cnt_q != '0);
  assign head     = mem_q[rptr_q[PTR_W-1:0]];

  // Ack looks at the pre-pop count, so a full queue never acks even while popping.
  assign b2r_ack    = r2b_req & (cnt_q != CNT_W'(DEPTH));
  assign b2r_arb_ok = (cnt_q <= CNT_W'(DEPTH - 2));
  assign push       = b2r_ack;

  // Report priority: pre_all > pre > act > pop; losers are dropped that cycle.
  assign pre_eff = head_vld & x2q_pre & ~x2q_pre_all;
  assign act_eff = head_vld & x2q_act & ~x2q_pre & ~x2q_pre_all;
  assign pop     = head_vld & x2q_pop & ~x2q_act & ~x2q_pre & ~x2q_pre_all;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q[PTR_W-1:0]] = in_req;
      wptr_d = wptr_q + CNT_W'(1);
    end
    if (pop) rptr_d = rptr_q + CNT_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    sdrc_bank_queue_bank u_bank (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (x2q_pre_all | (pre_eff & (head.ba == 2'(b)))),
      .set    (act_eff & (head.ba == 2'(b))),
      .row_in (head.raddr),
      .open   (bank_open[b]),
      .row    (bank_row[b])
    );
  end

  always_comb begin
    cmd = CMD_ACT;
    if (bank_open[head.ba]) cmd = (bank_row[head.ba] == head.raddr) ? CMD_RW : CMD_PRE;
  end

  assign q_valid = head_vld;
  assign q_id    = head_vld ? head.id    : '0;
  assign q_ba    = head_vld ? head.ba    : '0;
  assign q_raddr = head_vld ? head.raddr : '0;
  assign q_caddr = head_vld ? head.caddr : '0;
  assign q_len   = head_vld ? head.len   : '0;
  assign q_write = head_vld & head.write;
  assign q_start = head_vld & head.start;
  assign q_last  = head_vld & head.last;
  assign q_wrap  = head_vld & head.wrap;
  assign q_cmd   = head_vld ? cmd : '0;

`ifdef SDR_BANKQ_STATS_EN
  logic [15:0] act_cnt_d, act_cnt_q, pop_cnt_d, pop_cnt_q;

  always_comb begin
    act_cnt_d = act_cnt_q;
    pop_cnt_d = pop_cnt_q;
    if (act_eff && act_cnt_q != 16'hFFFF) act_cnt_d = act_cnt_q + 16'd1;
    if (pop && pop_cnt_q != 16'hFFFF)     pop_cnt_d = pop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_cnt_q <= '0;
      pop_cnt_q <= '0;
    end else begin
      act_cnt_q <= act_cnt_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

  assign act_cnt = act_cnt_q;
  assign pop_cnt = pop_cnt_q;
`else
  assign act_cnt = '0;
  assign pop_cnt = '0;
`endif
endmodule

// File: tb/tb_sdrc_bank_queue.sv
// Bench for sdrc_bank_queue: queue/table reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.

module tb_sdrc_bank_queue;
  localparam int DEPTH = 4;
`ifdef SDR_BANKQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        r2b_req = 1'b0;
  logic [3:0]  r2b_req_id = '0;
  logic [1:0]  r2b_ba = '0;
  logic [11:0] r2b_raddr = '0, r2b_caddr = '0, r2b_len = '0;
  logic        r2b_write = 1'b0, r2b_start = 1'b0, r2b_last = 1'b0, r2b_wrap = 1'b0;
  logic        x2q_pre_all = 1'b0, x2q_pre = 1'b0, x2q_act = 1'b0, x2q_pop = 1'b0;
  logic        b2r_ack, b2r_arb_ok, q_valid, q_write, q_start, q_last, q_wrap;
  logic [3:0]  q_id;
  logic [1:0]  q_ba, q_cmd;
  logic [11:0] q_raddr, q_caddr, q_len;
  logic [15:0] act_cnt, pop_cnt;

  sdrc_bank_queue #(.REQ_ID_W(4), .REQ_BW(12), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .r2b_req(r2b_req), .r2b_req_id(r2b_req_id), .r2b_ba(r2b_ba), .r2b_raddr(r2b_raddr),
    .r2b_caddr(r2b_caddr), .r2b_len(r2b_len), .r2b_write(r2b_write), .r2b_start(r2b_start),
    .r2b_last(r2b_last), .r2b_wrap(r2b_wrap),
    .b2r_ack(b2r_ack), .b2r_arb_ok(b2r_arb_ok),
    .q_valid(q_valid), .q_id(q_id), .q_ba(q_ba), .q_raddr(q_raddr), .q_caddr(q_caddr),
    .q_len(q_len), .q_write(q_write), .q_start(q_start), .q_last(q_last), .q_wrap(q_wrap),
    .q_cmd(q_cmd),
    .x2q_pre_all(x2q_pre_all), .x2q_pre(x2q_pre), .x2q_act(x2q_act), .x2q_pop(x2q_pop),
    .act_cnt(act_cnt), .pop_cnt(pop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  ba;
    logic [11:0] raddr, caddr, len;
    logic        write, start, last, wrap;
  } ent_t;

  ent_t        mq[$];
  bit          m_open[4];
  logic [11:0] m_row[4];
  int          m_act, m_pop;
  int          n_chk, n_fail;
  bit          armed, last_ack;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [1:0] exp_cmd();
    if (mq.size() == 0) return 2'b00;
    if (!m_open[mq[0].ba]) return 2'b01;
    return (m_row[mq[0].ba] == mq[0].raddr) ? 2'b00 : 2'b10;
  endfunction

  function automatic bit exp_ack();
    return r2b_req && (mq.size() != DEPTH);
  endfunction

  task automatic check_all();
    ent_t h;
    bit   v = (mq.size() != 0);
    h = '{default: 0};
    if (v) h = mq[0];
    chk("ack", b2r_ack, exp_ack());
    chk("arb_ok", b2r_arb_ok, (DEPTH - mq.size()) >= 2);
    chk("q_valid", q_valid, v);
    chk("q_id", q_id, h.id);
    chk("q_ba", q_ba, h.ba);
    chk("q_raddr", q_raddr, h.raddr);
    chk("q_caddr", q_caddr, h.caddr);
    chk("q_len", q_len, h.len);
    chk("q_flags", {q_write, q_start, q_last, q_wrap}, {h.write, h.start, h.last, h.wrap});
    chk("q_cmd", q_cmd, exp_cmd());
    chk("act_cnt", act_cnt, STATS ? m_act : 0);
    chk("pop_cnt", pop_cnt, STATS ? m_pop : 0);
  endtask

  task automatic model_next();
    bit   v   = (mq.size() != 0);
    bit   ack = exp_ack();
    ent_t e;
    if (!reset_n) begin
      mq.delete();
      foreach (m_open[b]) m_open[b] = 1'b0;
      m_act = 0;
      m_pop = 0;
      return;
    end
    e = '{id: r2b_req_id, ba: r2b_ba, raddr: r2b_raddr, caddr: r2b_caddr, len: r2b_len,
          write: r2b_write, start: r2b_start, last: r2b_last, wrap: r2b_wrap};
    if (x2q_pre_all) begin
      foreach (m_open[b]) m_open[b] = 1'b0;
    end else if (x2q_pre) begin
      if (v) m_open[mq[0].ba] = 1'b0;
    end else if (x2q_act) begin
      if (v) begin
        m_open[mq[0].ba] = 1'b1;
        m_row[mq[0].ba]  = mq[0].raddr;
        if (m_act < 65535) m_act++;
      end
    end else if (x2q_pop && v) begin
      void'(mq.pop_front());
      if (m_pop < 65535) m_pop++;
    end
    if (ack) mq.push_back(e);
  endtask

  // Inputs are driven at the falling edge; outputs checked 1 time unit later.
  task automatic step();
    #1;
    if (armed) check_all();
    last_ack = exp_ack();
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    r2b_req = 1'b0;
    x2q_pre_all = 1'b0; x2q_pre = 1'b0; x2q_act = 1'b0; x2q_pop = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] id, input logic [1:0] ba, input logic [11:0] ra,
                           input logic [11:0] ca, input logic [11:0] len, input logic wr,
                           input logic st, input logic ls);
    r2b_req = 1'b1; r2b_req_id = id; r2b_ba = ba; r2b_raddr = ra; r2b_caddr = ca;
    r2b_len = len; r2b_write = wr; r2b_start = st; r2b_last = ls; r2b_wrap = 1'b0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    armed = 1'b1;
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q_cmd", q_cmd, 0);
    chk("rst_arb_ok", b2r_arb_ok, 1);
    chk("rst_act_cnt", act_cnt, 0);

    // Single chunk: ACT -> RW -> pop
    drive_req(4'd3, 2'd1, 12'h0A5, 12'h010, 12'd8, 1'b1, 1'b1, 1'b1);
    #1 chk("t1_ack", b2r_ack, 1);
    step(); idle();
    chk("t1_valid", q_valid, 1);
    chk("t1_cmd_act", q_cmd, 2'b01);
    x2q_act = 1'b1; step(); idle();
    chk("t1_cmd_rw", q_cmd, 2'b00);
    x2q_pop = 1'b1; step(); idle();
    chk("t1_empty", q_valid, 0);

    // Row miss on open bank: PRE -> ACT -> RW
    drive_req(4'd4, 2'd1, 12'h0A6, 12'h020, 12'd4, 1'b0, 1'b1, 1'b1);
    step(); idle();
    chk("t2_cmd_pre", q_cmd, 2'b10);
    x2q_pre = 1'b1; step(); idle();
    chk("t2_cmd_act", q_cmd, 2'b01);
    x2q_act = 1'b1; step(); idle();
    chk("t2_cmd_rw", q_cmd, 2'b00);
    x2q_pop = 1'b1; step(); idle();

    // Fill, full back-pressure, full with pop, drain
    for (int i = 0; i < 3; i++) begin
      drive_req(4'(i), 2'd3, 12'h300 + 12'(i), 12'h000, 12'd16, 1'b0, 1'b1, 1'b1);
      step();
    end
    idle();
    chk("t3_arb_ok_low", b2r_arb_ok, 0);
    drive_req(4'd3, 2'd3, 12'h303, 12'h000, 12'd16, 1'b0, 1'b1, 1'b1);
    #1 chk("t3_ack_4th", b2r_ack, 1);
    step();
    drive_req(4'd4, 2'd3, 12'h304, 12'h000, 12'd16, 1'b0, 1'b1, 1'b1);
    #1 chk("t3_ack_full", b2r_ack, 0);
    step();
    x2q_pop = 1'b1;
    #1 chk("t3_ack_full_pop", b2r_ack, 0);
    step();
    x2q_pop = 1'b0;
    #1 chk("t3_ack_after_pop", b2r_ack, 1);
    step(); idle();
    chk("t3_head_id", q_id, 4'd1);
    repeat (4) begin x2q_pop = 1'b1; step(); end
    idle();
    chk("t3_drained", q_valid, 0);

    // Page-split pair on back-to-back cycles
    drive_req(4'd5, 2'd0, 12'h050, 12'h1F8, 12'd8, 1'b1, 1'b1, 1'b0);
    #1 chk("t4_ack0", b2r_ack, 1);
    step();
    drive_req(4'd6, 2'd0, 12'h051, 12'h000, 12'd8, 1'b1, 1'b0, 1'b1);
    #1 chk("t4_ack1", b2r_ack, 1);
    step(); idle();
    chk("t4_id0", q_id, 4'd5);
    chk("t4_sl0", {q_start, q_last}, 2'b10);
    chk("t4_ca0", q_caddr, 12'h1F8);
    x2q_pop = 1'b1; step(); idle();
    chk("t4_id1", q_id, 4'd6);
    chk("t4_sl1", {q_start, q_last}, 2'b01);
    chk("t4_ra1", q_raddr, 12'h051);
    x2q_pop = 1'b1; step(); idle();

    // Open banks 0 and 2, then pre_all together with act
    drive_req(4'd7, 2'd0, 12'h100, 12'h000, 12'd1, 1'b0, 1'b1, 1'b1); step(); idle();
    x2q_act = 1'b1; step(); idle();
    x2q_pop = 1'b1; step(); idle();
    drive_req(4'd8, 2'd2, 12'h200, 12'h000, 12'd1, 1'b0, 1'b1, 1'b1); step(); idle();
    x2q_act = 1'b1; step(); idle();
    x2q_pop = 1'b1; step(); idle();
    drive_req(4'd9, 2'd2, 12'h200, 12'h000, 12'd1, 1'b0, 1'b1, 1'b1); step(); idle();
    chk("t5_cmd_rw", q_cmd, 2'b00);
    x2q_pre_all = 1'b1; x2q_act = 1'b1; step(); idle();
    chk("t5_cmd_act", q_cmd, 2'b01);
    chk("t5_act_cnt", act_cnt, STATS ? 4 : 0);
    chk("t5_pop_cnt", pop_cnt, STATS ? 11 : 0);
    x2q_pop = 1'b1; step(); idle();
    drive_req(4'd10, 2'd0, 12'h100, 12'h000, 12'd1, 1'b0, 1'b1, 1'b1); step(); idle();
    chk("t5_bank0_closed", q_cmd, 2'b01);
    x2q_pop = 1'b1; step(); idle();

    // Randomized traffic, with requests held stable until acked
    for (int n = 0; n < 3000; n++) begin
      if (!(r2b_req && !last_ack)) begin
        r2b_req    = ($urandom_range(0, 2) != 0);
        r2b_req_id = 4'($urandom);
        r2b_ba     = 2'($urandom);
        r2b_raddr  = 12'($urandom_range(0, 3));
        r2b_caddr  = 12'($urandom);
        r2b_len    = 12'($urandom);
        r2b_write  = 1'($urandom);
        r2b_start  = 1'($urandom);
        r2b_last   = 1'($urandom);
        r2b_wrap   = 1'($urandom);
      end
      x2q_pre_all = ($urandom_range(0, 39) == 0);
      x2q_pre     = ($urandom_range(0, (exp_cmd() == 2'b10) ? 1 : 7) == 0);
      x2q_act     = ($urandom_range(0, (exp_cmd() == 2'b01) ? 1 : 7) == 0);
      x2q_pop     = ($urandom_range(0, (exp_cmd() == 2'b00) ? 1 : 7) == 0);
      reset_n     = ($urandom_range(0, 299) != 0);
      step();
    end
    idle();
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
